// File: rtl/round_timer_if.sv
// round_timer_if: control/status bundle between the game FSM and the round timer.
// master = game side (drives tick/start/load_val/hit/abort), slave = timer side.
interface round_timer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             tick;
    logic             start;
    logic [CNT_W-1:0] load_val;
    logic             hit;
    logic             abort;
    logic             busy;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] elapsed;
    logic             expired;
    logic             hit_ok;

    modport master (
        output tick, start, load_val, hit, abort,
        input  busy, remaining, elapsed, expired, hit_ok
    );

    modport slave (
        input  tick, start, load_val, hit, abort,
        output busy, remaining, elapsed, expired, hit_ok
    );
endinterface

// File: rtl/round_timer.sv
// round_timer: counts divider ticks down from a loaded value for the reaction
// window, reporting a hit (hit_ok) or timeout (expired) as one-cycle pulses,
// plus remaining/elapsed tick counts. All outputs are registered.
// Optional macro ROUND_TIMER_TICK_EDGE_EN: register tick and count only its
// rising edges (one extra cycle of tick latency); otherwise tick is a level strobe.
module round_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    round_timer_if.slave        bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic             busy_q, busy_d;
    logic             expired_q, expired_d;
    logic             hit_ok_q, hit_ok_d;
    logic             tick_evt;

`ifdef ROUND_TIMER_TICK_EDGE_EN
    logic tick_q, tick_prev_q;

    // Synchronise tick and keep its previous value for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q      <= 1'b0;
            tick_prev_q <= 1'b0;
        end else begin
            tick_q      <= bus.tick;
            tick_prev_q <= tick_q;
        end
    end

    assign tick_evt = tick_q & ~tick_prev_q;
`else
    assign tick_evt = bus.tick;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            elapsed_q   <= '0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
            hit_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            elapsed_q   <= elapsed_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
            hit_ok_q    <= hit_ok_d;
        end
    end

    // Next-state and next-output logic; in RUN abort beats hit beats tick.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        elapsed_d   = elapsed_q;
        expired_d   = 1'b0;
        hit_ok_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    elapsed_d = '0;
                    if (bus.load_val != '0) begin
                        remaining_d = bus.load_val;
                        state_d     = RUN;
                    end else begin
                        remaining_d = '0;
                        expired_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    remaining_d = '0;
                    state_d     = IDLE;
                end else if (bus.hit) begin
                    hit_ok_d = 1'b1;
                    state_d  = IDLE;
                end else if (tick_evt) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (elapsed_q != '1) begin
                        elapsed_d = elapsed_q + CNT_W'(1);
                    end
                    if (remaining_q == CNT_W'(1)) begin
                        expired_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    assign bus.busy      = busy_q;
    assign bus.remaining = remaining_q;
    assign bus.elapsed   = elapsed_q;
    assign bus.expired   = expired_q;
    assign bus.hit_ok    = hit_ok_q;

endmodule
